// File: rtl/commit_trace_fifo.sv
// Timestamped show-ahead FIFO of processor regfile/dmem write events, drained over valid/ready.
// Define TRACE_TIMESTAMP_EN to keep the free-running cycle counter and per-entry stamp.
module commit_trace_fifo #(
    parameter int DEPTH   = 16,
    parameter int CYCLE_W = 16,
    parameter int DROP_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     ctrl_writeEnable,
    input  logic [4:0]               ctrl_writeReg,
    input  logic [31:0]              data_writeReg,
    input  logic                     wren,
    input  logic [11:0]              address_dmem,
    input  logic [31:0]              data,
    input  logic                     trace_ready,
    output logic                     trace_valid,
    output logic [CYCLE_W-1:0]       trace_cycle,
    output logic                     trace_reg_v,
    output logic [4:0]               trace_rd,
    output logic [31:0]              trace_rdata,
    output logic                     trace_mem_v,
    output logic [11:0]              trace_maddr,
    output logic [31:0]              trace_mdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int PAY_W = 1 + 5 + 32 + 1 + 12 + 32;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                 reg_ev_p0;
    logic                 mem_ev_p0;
    logic                 vld_p0;
    logic [PAY_W-1:0]     payload_p0;
    logic                 full;
    logic                 pop;
    logic                 push_ok;
    logic                 drop;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [PAY_W-1:0]     payload_mem [DEPTH];
    logic [PAY_W-1:0]     head;

    // Stage p0: qualify the tapped write buses into one candidate entry
    assign reg_ev_p0  = ctrl_writeEnable && (ctrl_writeReg != 5'd0);
    assign mem_ev_p0  = wren;
    assign vld_p0     = enable && (reg_ev_p0 || mem_ev_p0);
    assign payload_p0 = {reg_ev_p0, ctrl_writeReg, data_writeReg,
                         mem_ev_p0, address_dmem, data};

    assign full    = (count == FULL_CNT);
    assign pop     = trace_valid && trace_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push_ok = vld_p0 && (!full || pop);
    assign drop    = vld_p0 && full && !pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= sat_inc(drop_count);
            end
        end
    end

    // Stage p1: entry storage, deliberately left uncleared by reset
    always_ff @(posedge clock) begin
        if (push_ok) payload_mem[wr_ptr] <= payload_p0;
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [CYCLE_W-1:0] cycle_cnt;
    logic [CYCLE_W-1:0] stamp_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) cycle_cnt <= '0;
        else       cycle_cnt <= cycle_cnt + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (push_ok) stamp_mem[wr_ptr] <= cycle_cnt;
    end

    assign trace_cycle = stamp_mem[rd_ptr];
`else
    assign trace_cycle = '0;
`endif

    // Show-ahead head decode
    assign head        = payload_mem[rd_ptr];
    assign trace_valid = (count != '0);
    assign trace_reg_v = head[82];
    assign trace_rd    = head[81:77];
    assign trace_rdata = head[76:45];
    assign trace_mem_v = head[44];
    assign trace_maddr = head[43:32];
    assign trace_mdata = head[31:0];

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Randomized and directed bench for commit_trace_fifo against a queue-based reference model.
module tb_commit_trace_fifo;

    localparam int DEPTH   = 16;
    localparam int CYCLE_W = 16;
    localparam int DROP_W  = 4;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic                clock = 1'b0;
    logic                reset, enable, ctrl_writeEnable, wren, trace_ready;
    logic [4:0]          ctrl_writeReg;
    logic [31:0]         data_writeReg, data;
    logic [11:0]         address_dmem;
    logic                trace_valid, trace_reg_v, trace_mem_v, overflow;
    logic [CYCLE_W-1:0]  trace_cycle;
    logic [4:0]          trace_rd;
    logic [31:0]         trace_rdata, trace_mdata;
    logic [11:0]         trace_maddr;
    logic [4:0]          count;
    logic [DROP_W-1:0]   drop_count;

    commit_trace_fifo #(.DEPTH(DEPTH), .CYCLE_W(CYCLE_W), .DROP_W(DROP_W)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .wren(wren), .address_dmem(address_dmem),
        .data(data), .trace_ready(trace_ready), .trace_valid(trace_valid),
        .trace_cycle(trace_cycle), .trace_reg_v(trace_reg_v), .trace_rd(trace_rd),
        .trace_rdata(trace_rdata), .trace_mem_v(trace_mem_v), .trace_maddr(trace_maddr),
        .trace_mdata(trace_mdata), .count(count), .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [CYCLE_W-1:0] cyc;
        logic               reg_v;
        logic [4:0]         rd;
        logic [31:0]        rdata;
        logic               mem_v;
        logic [11:0]        maddr;
        logic [31:0]        mdata;
    } ent_t;

    ent_t               q[$];
    logic [CYCLE_W-1:0] m_cycle;
    logic               m_ovf;
    logic [DROP_W-1:0]  m_drop;
    int                 total = 0;
    int                 bad = 0;

    function automatic logic [CYCLE_W-1:0] exp_stamp(input logic [CYCLE_W-1:0] c);
`ifdef TRACE_TIMESTAMP_EN
        return c;
`else
        return '0;
`endif
    endfunction

    task automatic drive(input logic en, input logic we, input logic [4:0] wr,
                         input logic [31:0] wd, input logic mw, input logic [11:0] ad,
                         input logic [31:0] md, input logic rdy);
        enable = en; ctrl_writeEnable = we; ctrl_writeReg = wr; data_writeReg = wd;
        wren = mw; address_dmem = ad; data = md; trace_ready = rdy;
    endtask

    // Advance one clock and apply the architectural rules to the model queue.
    task automatic tick();
        ent_t e;
        bit pop, req, full;
        pop  = (q.size() != 0) && trace_ready;
        e.reg_v = ctrl_writeEnable && (ctrl_writeReg != 5'd0);
        e.mem_v = wren;
        req  = enable && (e.reg_v || e.mem_v);
        full = (q.size() == DEPTH);
        e.cyc = m_cycle; e.rd = ctrl_writeReg; e.rdata = data_writeReg;
        e.maddr = address_dmem; e.mdata = data;
        @(posedge clock);
        if (reset) begin
            q.delete(); m_cycle = '0; m_ovf = 1'b0; m_drop = '0;
        end else begin
            if (pop) void'(q.pop_front());
            if (req) begin
                if (!full || pop) q.push_back(e);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop != DROP_MAX) m_drop = m_drop + 1'b1;
                end
            end
            m_cycle = m_cycle + 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (trace_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", trace_valid); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        total++; if (drop_count !== '0) begin bad++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    endtask

    task automatic test_reg_write();
        do_reset();
        repeat (3) tick();
        drive(1, 1, 5, 42, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (trace_valid !== 1'b1) begin bad++; $display("FAIL regw_valid: got %b want 1", trace_valid); end
        total++; if (trace_reg_v !== 1'b1 || trace_mem_v !== 1'b0) begin bad++; $display("FAIL regw_kind: got reg_v=%b mem_v=%b want 1 0", trace_reg_v, trace_mem_v); end
        total++; if (trace_rd !== 5'd5 || trace_rdata !== 32'd42) begin bad++; $display("FAIL regw_data: got r%0d=%0d want r5=42", trace_rd, trace_rdata); end
        total++; if (trace_cycle !== exp_stamp(16'd3)) begin bad++; $display("FAIL regw_cycle: got %0d want %0d", trace_cycle, exp_stamp(16'd3)); end
        total++; if (count !== 5'd1) begin bad++; $display("FAIL regw_count: got %0d want 1", count); end
    endtask

    task automatic test_r0();
        do_reset();
        drive(1, 1, 0, 7, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (count !== 5'd0 || trace_valid !== 1'b0) begin bad++; $display("FAIL r0_ignored: got count=%0d valid=%b want 0 0", count, trace_valid); end
    endtask

    task automatic test_both();
        do_reset();
        drive(1, 1, 2, 32'hFFFF_FFFF, 1, 12'd100, 32'd9, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (count !== 5'd1) begin bad++; $display("FAIL both_count: got %0d want 1", count); end
        total++; if (trace_reg_v !== 1'b1 || trace_rd !== 5'd2 || trace_rdata !== 32'hFFFF_FFFF)
            begin bad++; $display("FAIL both_reg: got v=%b r%0d=%h want 1 r2=ffffffff", trace_reg_v, trace_rd, trace_rdata); end
        total++; if (trace_mem_v !== 1'b1 || trace_maddr !== 12'd100 || trace_mdata !== 32'd9)
            begin bad++; $display("FAIL both_mem: got v=%b [%0d]=%0d want 1 [100]=9", trace_mem_v, trace_maddr, trace_mdata); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(1, 1, 5'((i % 31) + 1), i, 0, 0, 0, 0);
            tick();
        end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count: got %0d want 16", count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        total++; if (drop_count !== 4'd2) begin bad++; $display("FAIL ovf_drop: got %0d want 2", drop_count); end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            total++; if (trace_valid !== 1'b1 || trace_rdata !== 32'(i))
                begin bad++; $display("FAIL drain_order[%0d]: got v=%b d=%0d want 1 %0d", i, trace_valid, trace_rdata, i); end
            total++; if (trace_cycle !== exp_stamp(16'(i)))
                begin bad++; $display("FAIL drain_stamp[%0d]: got %0d want %0d", i, trace_cycle, exp_stamp(16'(i))); end
            tick();
        end
        total++; if (count !== 5'd0 || trace_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got count=%0d valid=%b want 0 0", count, trace_valid); end
    endtask

    task automatic test_drop_sat();
        do_reset();
        for (int i = 0; i < 16 + 20; i++) begin
            drive(1, 0, 0, 0, 1, 12'(i), i, 0);
            tick();
        end
        total++; if (drop_count !== DROP_MAX) begin bad++; $display("FAIL drop_saturate: got %0d want %0d", drop_count, DROP_MAX); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 3, i, 0, 0, 0, 0);
            tick();
        end
        drive(1, 1, 3, 32'hABCD, 0, 0, 0, 1);
        tick();
        total++; if (count !== 5'd16 || overflow !== 1'b0 || drop_count !== '0)
            begin bad++; $display("FAIL fullpp_state: got count=%0d ovf=%b drop=%0d want 16 0 0", count, overflow, drop_count); end
        total++; if (trace_rdata !== 32'd1) begin bad++; $display("FAIL fullpp_head: got %0d want 1", trace_rdata); end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (15) tick();
        total++; if (count !== 5'd1 || trace_rdata !== 32'hABCD)
            begin bad++; $display("FAIL fullpp_tail: got count=%0d d=%h want 1 abcd", count, trace_rdata); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, 0, 0, 0, 1, 12'(i), i, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (11) tick();
        total++; if (count !== 5'd5 || overflow !== 1'b1) begin bad++; $display("FAIL rmid_pre: got count=%0d ovf=%b want 5 1", count, overflow); end
        do_reset();
        total++; if (count !== 5'd0 || trace_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== '0)
            begin bad++; $display("FAIL rmid_cleared: got count=%0d v=%b ovf=%b drop=%0d want 0 0 0 0", count, trace_valid, overflow, drop_count); end
        drive(1, 1, 9, 1, 0, 0, 0, 0);
        tick();
        total++; if (trace_valid !== 1'b1 || trace_cycle !== '0)
            begin bad++; $display("FAIL rmid_stamp: got v=%b cyc=%0d want 1 0", trace_valid, trace_cycle); end
    endtask

    task automatic test_random();
        logic [4:0] exp_cnt;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 2) == 0, 12'($urandom), $urandom,
                  (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            tick();
            reset = 1'b0;
            exp_cnt = 5'(q.size());
            total++; if (count !== exp_cnt || trace_valid !== (q.size() != 0))
                begin bad++; $display("FAIL rnd_count[%0d]: got %0d/%b want %0d", i, count, trace_valid, exp_cnt); end
            total++; if (overflow !== m_ovf || drop_count !== m_drop)
                begin bad++; $display("FAIL rnd_drop[%0d]: got %b/%0d want %b/%0d", i, overflow, drop_count, m_ovf, m_drop); end
            if (q.size() != 0) begin
                total++; if (trace_reg_v !== q[0].reg_v || trace_mem_v !== q[0].mem_v || trace_cycle !== exp_stamp(q[0].cyc))
                    begin bad++; $display("FAIL rnd_head[%0d]: got %b%b@%0d want %b%b@%0d", i, trace_reg_v, trace_mem_v, trace_cycle, q[0].reg_v, q[0].mem_v, exp_stamp(q[0].cyc)); end
                if (q[0].reg_v) begin
                    total++; if (trace_rd !== q[0].rd || trace_rdata !== q[0].rdata)
                        begin bad++; $display("FAIL rnd_reg[%0d]: got r%0d=%h want r%0d=%h", i, trace_rd, trace_rdata, q[0].rd, q[0].rdata); end
                end
                if (q[0].mem_v) begin
                    total++; if (trace_maddr !== q[0].maddr || trace_mdata !== q[0].mdata)
                        begin bad++; $display("FAIL rnd_mem[%0d]: got [%h]=%h want [%h]=%h", i, trace_maddr, trace_mdata, q[0].maddr, q[0].mdata); end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        m_cycle = '0; m_ovf = 1'b0; m_drop = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_reg_write();
        test_r0();
        test_both();
        test_overflow();
        test_drop_sat();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
